// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//   Shares one AXI-Stream port among NUM_REQUESTERS sources. The arbiter
//   grants whole packets in round-robin order. A grant is held until the
//   tlast beat of the packet is accepted. A 2-entry skid FIFO on the output
//   keeps out_tready from reaching in_tready combinationally.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_tvalid/in_tready    per-requester handshake
//   in_tdata/tlast/tid/tdest  per-requester payload, packed [req][bits]
//   out_tvalid/out_tready  shared output handshake (skid head entry)
//   out_tdata/tlast/tid/tdest shared output payload, passed through bit-exact
//   grant_valid, grant_id  registered view of the current packet holder
module axis_packet_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TID_WIDTH      = 2,
  parameter int TDEST_WIDTH    = 4,
  parameter int TDATA_WIDTH    = 512,
  localparam int GID_WIDTH     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQUESTERS-1:0]                    in_tvalid,
  output logic [NUM_REQUESTERS-1:0]                    in_tready,
  input  logic [NUM_REQUESTERS-1:0][TDATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_REQUESTERS-1:0]                    in_tlast,
  input  logic [NUM_REQUESTERS-1:0][TID_WIDTH-1:0]     in_tid,
  input  logic [NUM_REQUESTERS-1:0][TDEST_WIDTH-1:0]   in_tdest,
  output logic                                         out_tvalid,
  input  logic                                         out_tready,
  output logic [TDATA_WIDTH-1:0]                       out_tdata,
  output logic                                         out_tlast,
  output logic [TID_WIDTH-1:0]                         out_tid,
  output logic [TDEST_WIDTH-1:0]                       out_tdest,
  output logic                                         grant_valid,
  output logic [GID_WIDTH-1:0]                         grant_id
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
  } beat_t;

  state_e               state_q, state_d;
  logic [GID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [GID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]           count_q, count_d;
  beat_t                ent0_q, ent0_d;  // head
  beat_t                ent1_q, ent1_d;

  logic                 can_push, push, pop;
  logic                 winner_found;
  logic [GID_WIDTH-1:0] winner;
  logic [GID_WIDTH:0]   cand;
  beat_t                in_beat;

  // in_tready only looks at registered state, never at out_tready.
  assign can_push = (state_q == LOCKED) && (count_q != 2'd2);

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_rdy
    assign in_tready[g] = can_push && (grant_id_q == GID_WIDTH'(g));
  end

  assign in_beat.tdata = in_tdata[grant_id_q];
  assign in_beat.tlast = in_tlast[grant_id_q];
  assign in_beat.tid   = in_tid[grant_id_q];
  assign in_beat.tdest = in_tdest[grant_id_q];

  assign push = can_push && in_tvalid[grant_id_q];
  assign pop  = (count_q != 2'd0) && out_tready;

  // Round-robin search starting at rr_ptr. The wrap is an explicit compare
  // because NUM_REQUESTERS need not be a power of two.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    cand         = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, rr_ptr_q} + (GID_WIDTH+1)'(i);
      if (cand >= (GID_WIDTH+1)'(NUM_REQUESTERS))
        cand = cand - (GID_WIDTH+1)'(NUM_REQUESTERS);
      if (!winner_found && in_tvalid[cand[GID_WIDTH-1:0]]) begin
        winner_found = 1'b1;
        winner       = cand[GID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d    = LOCKED;
          grant_id_d = winner;
        end
      end
      LOCKED: begin
        if (push && in_beat.tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == GID_WIDTH'(NUM_REQUESTERS - 1)) ?
                     '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid FIFO: ent0 is always the head, ent1 only holds data when count==2.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = in_beat;
        else                 ent1_d = in_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = in_beat;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      count_q    <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

  assign out_tvalid  = (count_q != 2'd0);
  assign out_tdata   = ent0_q.tdata;
  assign out_tlast   = ent0_q.tlast;
  assign out_tid     = ent0_q.tid;
  assign out_tdest   = ent0_q.tdest;
  assign grant_valid = (state_q == LOCKED);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter with 3 requesters (non power of
// two, exercises the 2->0 wrap). A packet-level reference model predicts
// grants, in_tready, and the ordered stream of output beats.
module tb_axis_packet_arbiter;
  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int TIDW = 2;
  localparam int TDW  = 4;
  localparam int GW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         in_tvalid, in_tready, in_tlast;
  logic [N-1:0][DW-1:0] in_tdata;
  logic [N-1:0][TIDW-1:0] in_tid;
  logic [N-1:0][TDW-1:0]  in_tdest;
  logic                 out_tvalid, out_tready, out_tlast;
  logic [DW-1:0]        out_tdata;
  logic [TIDW-1:0]      out_tid;
  logic [TDW-1:0]       out_tdest;
  logic                 grant_valid;
  logic [GW-1:0]        grant_id;

  axis_packet_arbiter #(.NUM_REQUESTERS(N), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW),
                        .TDATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tlast(in_tlast), .in_tid(in_tid), .in_tdest(in_tdest),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast), .out_tid(out_tid), .out_tdest(out_tdest),
    .grant_valid(grant_valid), .grant_id(grant_id));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   d;
    logic            l;
    logic [TIDW-1:0] id;
    logic [TDW-1:0]  de;
  } beat_t;

  int checks = 0, errors = 0;

  // stimulus knobs
  logic [N-1:0] en;
  int vprob, rprob, fixed_len;
  // per-requester packet generators
  int plen[N], pbeat[N], pno[N];
  bit dacc[N];
  int acc_cnt;
  int glog[$];
  bit prev_gv;

  // reference model
  bit    m_locked;
  int    m_gid, m_rr;
  beat_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int new_len();
    return (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 4));
  endfunction

  function automatic beat_t cur_beat(input int r);
    beat_t b;
    b.d  = {8'(r), 8'(pno[r]), 16'(pbeat[r])};
    b.l  = (pbeat[r] == plen[r] - 1);
    b.id = TIDW'(pno[r]);
    b.de = TDW'(pno[r] + r);
    return b;
  endfunction

  task automatic set_len(input int l);
    fixed_len = l;
    for (int r = 0; r < N; r++) if (pbeat[r] == 0) plen[r] = new_len();
  endtask

  task automatic drive();
    beat_t b;
    for (int r = 0; r < N; r++) begin
      b = cur_beat(r);
      in_tvalid[r] = en[r] && ($urandom_range(99) < vprob);
      in_tdata[r]  = b.d;
      in_tlast[r]  = b.l;
      in_tid[r]    = b.id;
      in_tdest[r]  = b.de;
    end
    out_tready = ($urandom_range(99) < rprob);
  endtask

  task automatic advance();
    for (int r = 0; r < N; r++) if (dacc[r]) begin
      if (pbeat[r] == plen[r] - 1) begin
        pbeat[r] = 0; pno[r]++; plen[r] = new_len();
      end else pbeat[r]++;
    end
  endtask

  task automatic model_check();
    logic [N-1:0] er;
    bit acc, pop, found;
    int w, idx;
    beat_t b;
    for (int r = 0; r < N; r++) er[r] = m_locked && (r == m_gid) && (q.size() < 2);
    chk("in_tready", 64'(in_tready), 64'(er));
    chk("grant_valid", 64'(grant_valid), 64'(m_locked));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("out_tvalid", 64'(out_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_tdata", 64'(out_tdata), 64'(q[0].d));
      chk("out_tlast", 64'(out_tlast), 64'(q[0].l));
      chk("out_tid", 64'(out_tid), 64'(q[0].id));
      chk("out_tdest", 64'(out_tdest), 64'(q[0].de));
    end
    for (int r = 0; r < N; r++) begin
      dacc[r] = in_tvalid[r] && in_tready[r];
      if (dacc[r]) acc_cnt++;
    end
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
    prev_gv = grant_valid;

    pop = (q.size() != 0) && out_tready;
    acc = m_locked && in_tvalid[m_gid] && (q.size() < 2);
    b   = cur_beat(m_gid);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(b);
    if (!m_locked) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && in_tvalid[idx]) begin found = 1; w = idx; end
      end
      if (found) begin m_locked = 1; m_gid = w; end
    end else if (acc && b.l) begin
      m_locked = 0;
      m_rr = (m_gid + 1) % N;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    advance();
    drive();
  endtask

  // Let the current holder finish and the FIFO empty, with no new requests.
  task automatic drain();
    int k = 0;
    vprob = 100; rprob = 100;
    while ((m_locked || q.size() != 0) && k < 50) begin
      en = '0;
      if (m_locked) en[m_gid] = 1'b1;
      drive();
      step();
      k++;
    end
    chk("drain_timeout", 64'(k < 50), 64'(1));
    en = '0;
    drive();
  endtask

  task automatic model_reset();
    m_locked = 0; m_gid = 0; m_rr = 0; q.delete(); prev_gv = 0;
    for (int r = 0; r < N; r++) begin
      pbeat[r] = 0; pno[r]++; plen[r] = new_len(); dacc[r] = 0;
    end
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 0, 1};
    en = '0; vprob = 100; rprob = 100; fixed_len = 3; acc_cnt = 0;
    for (int r = 0; r < N; r++) begin plen[r] = 3; pbeat[r] = 0; pno[r] = 0; dacc[r] = 0; end
    m_locked = 0; m_gid = 0; m_rr = 0; prev_gv = 0;
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_grant_valid", 64'(grant_valid), 64'(0));
    chk("rst_in_tready", 64'(in_tready), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();

    // requester 2 alone, 3-beat packet
    en = 3'b100; set_len(3); drive();
    repeat (7) step();
    chk("t2_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'(2));
    drain();

    // everyone always valid, 2-beat packets: strict round-robin
    glog.delete();
    en = 3'b111; set_len(2); drive();
    repeat (16) step();
    for (int i = 0; i < 5; i++)
      chk("t3_order", 64'(glog.size() > i ? glog[i] : -1), 64'(exp_order[i]));
    drain();

    // output stalled: only two beats absorbed, then full recovery
    acc_cnt = 0;
    en = 3'b001; set_len(6); rprob = 0; drive();
    repeat (6) step();
    chk("t4_absorb", 64'(acc_cnt), 64'(2));
    rprob = 100; drive();
    repeat (5) step();
    chk("t4_total", 64'(acc_cnt), 64'(6));
    drain();

    // reset with a full skid buffer mid-packet
    en = 3'b001; set_len(6); rprob = 0; drive();
    repeat (5) step();
    chk("t5_full", 64'(out_tvalid && !in_tready[0] && grant_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("t5_in_tready", 64'(in_tready), 64'(0));
    chk("t5_grant_valid", 64'(grant_valid), 64'(0));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    glog.delete();
    en = 3'b110; set_len(2); rprob = 100; drive();
    repeat (4) step();
    chk("t5_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'(1));
    drain();

    // randomized valid, ready and packet lengths
    en = 3'b111; vprob = 70; rprob = 60; set_len(0); drive();
    repeat (3000) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
